// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding,
// register-file size and the ACK/NACK bus levels.
package i2c_target_pkg;

  localparam int unsigned NUM_REGS = 8;
  localparam logic        ACK      = 1'b0;
  localparam logic        NACK     = 1'b1;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StReg,
    StRegAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck
  } state_e;

endpackage

// File: rtl/i2c_target_sync.sv
// Bus front end: 2-FF synchronizers, optional 3-sample glitch filter
// (I2C_TARGET_FILTER_EN) and START/STOP/SCL-edge detection.
module i2c_target_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic start_o,
  output logic stop_o,
  output logic scl_rise_o,
  output logic scl_fall_o
);

  logic [1:0] scl_ff_q, sda_ff_q;
  logic       scl_s, sda_s;
  logic       scl_prev_q, sda_prev_q;

  // Reset to 1 so an idle bus does not look like an edge after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_ff_q <= 2'b11;
      sda_ff_q <= 2'b11;
    end else begin
      scl_ff_q <= {scl_ff_q[0], scl_i};
      sda_ff_q <= {sda_ff_q[0], sda_i};
    end
  end

`ifdef I2C_TARGET_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_filt_q, sda_filt_q;

  // Output follows the input once the last three samples agree.
  assign scl_s = (scl_hist_q == {2{scl_ff_q[1]}}) ? scl_ff_q[1] : scl_filt_q;
  assign sda_s = (sda_hist_q == {2{sda_ff_q[1]}}) ? sda_ff_q[1] : sda_filt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_ff_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_ff_q[1]};
      scl_filt_q <= scl_s;
      sda_filt_q <= sda_s;
    end
  end
`else
  assign scl_s = scl_ff_q[1];
  assign sda_s = sda_ff_q[1];
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign sda_o      = sda_s;
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target with an 8-entry byte register file shared with a host port;
// protocol FSM and register file live here, bus conditioning in i2c_target_sync.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] address,
  input  logic       chipselect,
  input  logic       write_n,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] ptr_q, ptr_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] readdata_q;
  logic [7:0] regs_q [NUM_REGS];

  logic       sda, start, stop, scl_rise, scl_fall;
  logic       i2c_we;
  logic [7:0] rx_byte;

  i2c_target_sync u_sync (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .scl_i      (scl_in),
    .sda_i      (sda_in),
    .sda_o      (sda),
    .start_o    (start),
    .stop_o     (stop),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall)
  );

  assign rx_byte = {shift_q[6:0], sda};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    i2c_we    = 1'b0;
    if (stop) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
    end else if (start) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr, StReg, StWdata: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (state_q == StAddr) begin
                state_d = (rx_byte[7:1] == DEV_ADDR) ? StAddrAck : StIdle;
              end else if (state_q == StReg) begin
                ptr_d   = rx_byte[2:0];
                state_d = StRegAck;
              end else begin
                i2c_we  = 1'b1;
                ptr_d   = ptr_q + 3'd1;
                state_d = StWdataAck;
              end
            end
          end
        end
        // First SCL fall after the 8th bit drives ACK, the next one releases it.
        StAddrAck, StRegAck, StWdataAck: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = StWdata;
              if (state_q == StAddrAck) begin
                if (shift_q[0]) begin
                  state_d  = StRdata;
                  shift_d  = regs_q[ptr_q];
                  sda_oe_d = ~regs_q[ptr_q][7];
                end else begin
                  state_d = StReg;
                end
              end
            end
          end
        end
        StRdata: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = StRdataAck;
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        // bit_cnt == 1 marks an ACK seen; the next byte loads on the following fall.
        StRdataAck: begin
          if (scl_rise) begin
            if (sda == NACK) begin
              state_d = StIdle;
            end else begin
              ptr_d     = ptr_q + 3'd1;
              bit_cnt_d = 4'd1;
            end
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            state_d   = StRdata;
            bit_cnt_d = '0;
            shift_d   = regs_q[ptr_q];
            sda_oe_d  = ~regs_q[ptr_q][7];
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  // The I2C write is issued last so it wins a same-cycle collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      readdata_q <= '0;
    end else begin
      if (chipselect && !write_n) regs_q[address] <= writedata;
      if (i2c_we) regs_q[ptr_q] <= rx_byte;
      if (chipselect) readdata_q <= regs_q[address];
    end
  end

  assign readdata = readdata_q;
  assign sda_oe   = sda_oe_q;
  assign busy     = (state_q != StIdle) && (state_q != StAddr);

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: acts as I2C controller and host, checks
// against a register/pointer model of the target.
module tb_i2c_target;

  localparam int Q = 10;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] address;
  logic       chipselect;
  logic       write_n;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       scl_drv, sda_drv;
  logic       scl_in, sda_in;
  logic       sda_oe, busy;

  int passed = 0;
  int total  = 0;

  logic [7:0] ref_regs [8];
  int         ref_ptr;
  logic [7:0] wq [$];

  int start_cnt = 0;
  int oe_busy_cnt = 0;
  logic found;

  assign scl_in = scl_drv;
  assign sda_in = sda_drv & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target #(.DEV_ADDR(7'h50)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .sda_oe     (sda_oe),
    .busy       (busy)
  );

  always @(negedge clk) if (dut.start) start_cnt++;
  always @(negedge clk) if (sda_oe || busy) oe_busy_cnt++;

  initial begin
    #1500000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "timeout");
  end

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %02h required %02h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b required %b", tag, obs, exp);
  endtask

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; qwait();
    scl_drv = 1'b1; qwait();
    sda_drv = 1'b0; qwait();
    scl_drv = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; qwait();
    scl_drv = 1'b1; qwait();
    sda_drv = 1'b1; qwait();
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_drv = b;    qwait();
    scl_drv = 1'b1; qwait();
    s = sda_in;     qwait();
    scl_drv = 1'b0; qwait();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic ack_bit, output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, s);
      d = {d[6:0], s};
    end
    clk_bit(ack_bit, s);
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    ref_regs[a] = d;
  endtask

  task automatic host_check(input logic [2:0] a, input string tag);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    @(negedge clk);
    chk8(tag, readdata, ref_regs[a]);
    chipselect = 1'b0;
  endtask

  // Writes the bytes in wq starting at register r.
  task automatic i2c_write(input logic [2:0] r);
    logic a;
    i2c_start();
    send_byte(8'hA0, a);        chk1("wr_addr_ack", a, 1'b0);
    chk1("busy_mid", busy, 1'b1);
    send_byte({5'd0, r}, a);    chk1("wr_reg_ack", a, 1'b0);
    ref_ptr = int'(r);
    foreach (wq[i]) begin
      send_byte(wq[i], a);      chk1("wr_data_ack", a, 1'b0);
      ref_regs[ref_ptr] = wq[i];
      ref_ptr = (ref_ptr + 1) % 8;
    end
    i2c_stop();
    chk1("busy_after_stop", busy, 1'b0);
  endtask

  // Reads n bytes, optionally setting the pointer first via repeated START.
  task automatic i2c_read(input logic set_ptr, input logic [2:0] r, input int n);
    logic a;
    logic [7:0] d;
    if (set_ptr) begin
      i2c_start();
      send_byte(8'hA0, a);      chk1("rd_set_addr_ack", a, 1'b0);
      send_byte({5'd0, r}, a);  chk1("rd_set_reg_ack", a, 1'b0);
      ref_ptr = int'(r);
    end
    i2c_start();
    send_byte(8'hA1, a);        chk1("rd_addr_ack", a, 1'b0);
    for (int k = 0; k < n; k++) begin
      recv_byte((k == n - 1) ? 1'b1 : 1'b0, d);
      chk8("rd_data", d, ref_regs[ref_ptr]);
      if (k != n - 1) ref_ptr = (ref_ptr + 1) % 8;
    end
    i2c_stop();
    chk1("busy_after_read", busy, 1'b0);
  endtask

  initial begin
    logic a;
    int   c0;
    int   op;
    int   n;
    scl_drv = 1'b1; sda_drv = 1'b1;
    chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    for (int i = 0; i < 8; i++) ref_regs[i] = '0;
    ref_ptr = 0;

    // Reset state
    reset_n = 1'b0;
    #1;
    chk1("rst_sda_oe", sda_oe, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk8("rst_readdata", readdata, 8'h00);
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) host_check(3'(i), "rst_reg");

    // Basic write: 0x5A, 0x3C into registers 2 and 3
    wq = {8'h5A, 8'h3C};
    i2c_write(3'd2);
    host_check(3'd2, "wr_reg2");
    host_check(3'd3, "wr_reg3");

    // Read with pointer wrap 7 -> 0
    host_write(3'd7, 8'h11);
    host_write(3'd0, 8'h22);
    i2c_read(1'b1, 3'd7, 2);

    // Address mismatch: no ACK, SDA never pulled, busy never set
    c0 = oe_busy_cnt;
    i2c_start();
    send_byte(8'hB0, a);
    chk1("mismatch_nack", a, 1'b1);
    chk8("mismatch_oe_busy", 8'(oe_busy_cnt - c0), 8'd0);
    i2c_stop();

    // Collision: host writes 0xFF to reg 4 on the same edge the I2C byte 0x33 lands
    i2c_start();
    send_byte(8'hA0, a);        chk1("col_addr_ack", a, 1'b0);
    send_byte(8'h04, a);        chk1("col_reg_ack", a, 1'b0);
    found = 1'b0;
    fork
      send_byte(8'h33, a);
      begin
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = 3'd4; writedata = 8'hFF;
        for (int i = 0; i < 2000 && !found; i++) begin
          @(negedge clk);
          if (dut.i2c_we) found = 1'b1;
        end
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
      end
    join
    chk1("col_strobe_seen", found, 1'b1);
    chk1("col_data_ack", a, 1'b0);
    i2c_stop();
    ref_regs[4] = 8'h33;
    ref_ptr = 5;
    host_check(3'd4, "col_reg4");

    // Glitch: 1-clk SDA low pulse while SCL high
    repeat (5) @(negedge clk);
    c0 = start_cnt;
    sda_drv = 1'b0;
    @(negedge clk);
    sda_drv = 1'b1;
    repeat (12) @(negedge clk);
`ifdef I2C_TARGET_FILTER_EN
    chk8("glitch_start", 8'(start_cnt - c0), 8'd0);
`else
    chk8("glitch_start", 8'(start_cnt - c0), 8'd1);
`endif
    chk1("glitch_busy", busy, 1'b0);

    // Reset in the middle of a read while the target pulls SDA low
    host_write(3'd6, 8'h00);
    wq = {};
    i2c_write(3'd6);
    i2c_start();
    send_byte(8'hA1, a);        chk1("mid_addr_ack", a, 1'b0);
    chk1("mid_sda_oe_driving", sda_oe, 1'b1);
    reset_n = 1'b0;
    #1;
    chk1("mid_rst_sda_oe", sda_oe, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    scl_drv = 1'b1;
    repeat (3) @(negedge clk);
    sda_drv = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) ref_regs[i] = '0;
    ref_ptr = 0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) host_check(3'(i), "mid_rst_reg");
    host_write(3'd0, 8'h9C);
    i2c_read(1'b0, 3'd0, 1);
    wq = {8'h77};
    i2c_write(3'd1);
    host_check(3'd1, "post_rst_wr");

    // Randomized mix of host and I2C traffic
    for (int it = 0; it < 14; it++) begin
      op = int'($urandom_range(0, 3));
      case (op)
        0: host_write(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        1: begin
          wq = {};
          n = int'($urandom_range(0, 3));
          for (int k = 0; k < n; k++) wq.push_back(8'($urandom_range(0, 255)));
          i2c_write(3'($urandom_range(0, 7)));
        end
        2: i2c_read(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    int'($urandom_range(1, 3)));
        default: host_check(3'($urandom_range(0, 7)), "rand_host_rd");
      endcase
    end
    for (int i = 0; i < 8; i++) host_check(3'(i), "final_reg");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 The module SHALL have parameter DEV_ADDR, default 7'h50, the 7-bit I2C target address it answers.
REQ-002 Port clk  input  1  system clock; all logic on its rising edge.
REQ-003 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Port address  input  3  host register index 0..7.
REQ-005 Port chipselect  input  1  host access enable.
REQ-006 Port write_n  input  1  host write strobe, active-low, qualified by chipselect.
REQ-007 Port writedata  input  8  host write data.
REQ-008 Port readdata  output  8  host read data, registered.
REQ-009 Port scl_in  input  1  I2C clock from bus; asynchronous to clk.
REQ-010 Port sda_in  input  1  I2C data from bus; asynchronous to clk.
REQ-011 Port sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-012 Port busy  output  1  1 while a transaction addressed to DEV_ADDR is in progress (ACK of address to STOP/START).

Function
REQ-013 scl_in/sda_in SHALL pass a 2-FF synchronizer; all protocol decisions use synchronized values; clk SHALL be at least 16x SCL.
REQ-014 START = synchronized SDA falls while SCL high; STOP = SDA rises while SCL high; both recognised in every state, START also as repeated start.
REQ-015 Bits SHALL be sampled on SCL rising edge; sda_oe changes only in the clk cycle after an SCL falling edge is detected.
REQ-016 States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-017 IDLE -> ADDR on START; ADDR shifts 8 bits MSB first; match of bits[7:1] with DEV_ADDR -> ADDR_ACK (sda_oe=1 for one SCL period), else IDLE with sda_oe=0 until next START.
REQ-018 After ADDR_ACK: R/W=0 -> REG; R/W=1 -> RDATA loading reg[ptr].
REQ-019 REG receives 8 bits; ptr <= byte[2:0]; REG_ACK ACKs; then WDATA.
REQ-020 WDATA receives 8 bits; reg[ptr] <= byte; ptr <= ptr+1 mod 8 (7 wraps to 0); WDATA_ACK ACKs; repeats until STOP/START.
REQ-021 RDATA drives reg[ptr] MSB first (sda_oe = ~bit); then releases SDA and samples controller ACK in RDATA_ACK; ACK(0) -> ptr+1 mod 8, next byte; NACK(1) -> IDLE.
REQ-022 STOP in any state -> IDLE, sda_oe=0 next cycle; START in any state -> ADDR; ptr retained across transactions.
REQ-023 Host write (chipselect & ~write_n) sets reg[address] <= writedata; host read gives readdata = reg[address] one cycle after chipselect.
REQ-024 Simultaneous host write and I2C write to the same register SHALL resolve with the I2C value stored.
REQ-025 A byte in RDATA SHALL be captured at load time; host writes during its transmission affect only the next read.

Reset
REQ-026 reset_n low SHALL immediately force: state IDLE, sda_oe 0, busy 0, readdata 0, ptr 0, shift register 0, all 8 registers 0, synchronizers to 1 (bus idle).
REQ-027 Reset mid-transaction SHALL release SDA asynchronously; after release the block waits for a new START.

Configuration
REQ-028 With I2C_TARGET_FILTER_EN defined, synchronized SCL/SDA SHALL pass a 3-sample stability filter (value changes only after 3 equal consecutive samples), adding 2 cycles latency; pulses <3 clk are ignored.
REQ-029 Without I2C_TARGET_FILTER_EN, synchronizer outputs feed edge detection directly.

Structure
REQ-030 Package i2c_target_pkg SHALL hold the state enum typedef, NUM_REGS=8, ACK=1'b0, NACK=1'b1.
REQ-031 Sub-module i2c_target_sync SHALL contain synchronizer, optional filter and START/STOP/SCL-edge detection; FSM and register file stay in i2c_target.

Verification
REQ-032 Write: START, 0xA0 ACK, 0x02 ACK, 0x5A ACK, 0x3C ACK, STOP -> host reads addr2=0x5A, addr3=0x3C; busy low after STOP.
REQ-033 Read wrap: host writes addr7=0x11, addr0=0x22; I2C sets ptr 7, repeated START, 0xA1, ACK, NACK -> bytes 0x11, 0x22 on bus.
REQ-034 Address mismatch: START, 0xB0 -> sda_oe stays 0 whole byte and ACK slot; busy stays 0.
REQ-035 Reset mid-read with sda_oe=1 -> sda_oe 0 same cycle, regs 0, next transaction from START works.
REQ-036 Filter build: 1-clk SDA low pulse while SCL high -> no START; non-filter build -> START detected.
REQ-037 Collision: host and I2C write addr4 same clk (host 0xFF, I2C 0x33) -> addr4 reads 0x33.
